// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory types: word, RAM status and arbiter state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - per-core icache/dcache memory ports plus the shared RAM port
interface mem_arbiter_if #(
    parameter int NCPU = 2
);
    import cpu_types_pkg::*;

    logic [NCPU-1:0]  iREN;
    word_t [NCPU-1:0] iaddr;
    logic [NCPU-1:0]  iwait;
    word_t [NCPU-1:0] iload;

    logic [NCPU-1:0]  dREN;
    logic [NCPU-1:0]  dWEN;
    word_t [NCPU-1:0] daddr;
    word_t [NCPU-1:0] dstore;
    logic [NCPU-1:0]  dwait;
    word_t [NCPU-1:0] dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin picker, first requester at or after ptr
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [PW-1:0] j;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!valid && req[j]) begin
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port among NCPU icache/dcache pairs, dcache first, round-robin cores
// Optional per-core grant/stall counters when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCPU        = 2,
    parameter int BLOCK_WORDS = 2
) (
    input  logic             CLK,
    input  logic             n_rst,
    mem_arbiter_if.slave     bus
`ifdef MEM_ARBITER_PERF_EN
    ,
    output word_t [NCPU-1:0] perf_grants,
    output word_t [NCPU-1:0] perf_stall
`endif
);

    localparam int PW = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int CW = $clog2(BLOCK_WORDS + 1);

    arb_state_t    state, state_n;
    logic [PW-1:0] owner, owner_n;
    logic [PW-1:0] rr_ptr, rr_ptr_n;
    logic [CW-1:0] word_cnt, word_cnt_n;

    logic [NCPU-1:0] d_req, d_gnt, i_gnt;
    logic            d_valid, i_valid;
    logic [PW-1:0]   d_idx, i_idx, owner_inc;

    assign d_req = bus.dREN | bus.dWEN;

    rr_picker #(.N(NCPU), .PW(PW)) u_pick_d (
        .req   (d_req),
        .ptr   (rr_ptr),
        .gnt   (d_gnt),
        .valid (d_valid)
    );

    rr_picker #(.N(NCPU), .PW(PW)) u_pick_i (
        .req   (bus.iREN),
        .ptr   (rr_ptr),
        .gnt   (i_gnt),
        .valid (i_valid)
    );

    always_comb begin
        d_idx = '0;
        i_idx = '0;
        for (int c = 0; c < NCPU; c++) begin
            if (d_gnt[c]) d_idx = PW'(c);
            if (i_gnt[c]) i_idx = PW'(c);
        end
    end

    // The releasing core drops to lowest priority for the next arbitration.
    assign owner_inc = (owner == PW'(NCPU - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        rr_ptr_n     = rr_ptr;
        word_cnt_n   = word_cnt;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.iload    = '0;
        bus.dload    = '0;
        case (state)
            IDLE: begin
                if (d_valid) begin
                    state_n    = GRANT_D;
                    owner_n    = d_idx;
                    word_cnt_n = '0;
                end else if (i_valid) begin
                    state_n    = GRANT_I;
                    owner_n    = i_idx;
                    word_cnt_n = '0;
                end
            end
            GRANT_D: begin
                if (!d_req[owner]) begin
                    state_n  = IDLE;
                    rr_ptr_n = owner_inc;
                end else begin
                    bus.ramaddr  = bus.daddr[owner];
                    bus.ramstore = bus.dstore[owner];
                    if (bus.dWEN[owner]) bus.ramWEN = 1'b1;
                    else                 bus.ramREN = bus.dREN[owner];
                    bus.dload[owner] = bus.ramload;
                    if (bus.ramstate == ACCESS) begin
                        bus.dwait[owner] = 1'b0;
                        word_cnt_n       = word_cnt + 1'b1;
                        if (word_cnt == CW'(BLOCK_WORDS - 1)) begin
                            state_n  = IDLE;
                            rr_ptr_n = owner_inc;
                        end
                    end
                end
            end
            GRANT_I: begin
                if (!bus.iREN[owner]) begin
                    state_n  = IDLE;
                    rr_ptr_n = owner_inc;
                end else begin
                    bus.ramaddr      = bus.iaddr[owner];
                    bus.ramREN       = 1'b1;
                    bus.iload[owner] = bus.ramload;
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait[owner] = 1'b0;
                        state_n          = IDLE;
                        rr_ptr_n         = owner_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            word_cnt <= word_cnt_n;
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    logic [NCPU-1:0] any_req;
    assign any_req = bus.iREN | bus.dREN | bus.dWEN;

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int c = 0; c < NCPU; c++) begin
                if (state == IDLE && state_n != IDLE && owner_n == PW'(c))
                    perf_grants[c] <= perf_grants[c] + 32'd1;
                if (any_req[c] && !(state != IDLE && owner == PW'(c)))
                    perf_stall[c] <= perf_stall[c] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM port between the instruction and data caches of NCPU cores. Sits between the per-core icache/dcache memory-side ports and the RAM model, in place of direct wiring. A granted dcache owns the RAM for a full block refill or writeback of BLOCK_WORDS accesses, so the two words of a block are never interleaved with another requester's traffic. Arbitration is fixed-priority dcache-over-icache and round-robin across cores.

## Interface
Parameters:
- NCPU, 2, number of cores (1..4)
- BLOCK_WORDS, 2, maximum RAM accesses per dcache grant

Ports:
- CLK  in  1  rising-edge clock
- n_rst  in  1  asynchronous active-low reset
- iREN  in  NCPU  icache read request, one bit per core
- iaddr  in  NCPU x 32  icache word address
- iwait  out  NCPU  icache stall; 0 for one cycle when read data is valid
- iload  out  NCPU x 32  icache read data
- dREN  in  NCPU  dcache read request
- dWEN  in  NCPU  dcache write request
- daddr  in  NCPU x 32  dcache word address
- dstore  in  NCPU x 32  dcache write data
- dwait  out  NCPU  dcache stall; 0 for one cycle per completed access
- dload  out  NCPU x 32  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

## Operation
- States: IDLE, GRANT_D, GRANT_I. Registers: owner (core index), word_cnt, and rr_ptr (the core with highest priority next).
- IDLE: scan cores starting at rr_ptr. The first core with dREN|dWEN is granted → GRANT_D. If no core has a dcache request, the first core with iREN is granted → GRANT_I. With no requests, stay in IDLE. word_cnt is cleared on every grant.
- GRANT_D:
  - Drive ramaddr = daddr[owner] and ramstore = dstore[owner].
  - If dWEN[owner]=1, assert ramWEN=1 and ramREN=0; a write wins when dWEN and dREN are both high. Otherwise assert ramREN = dREN[owner].
  - daddr may change between words; it is passed through unregistered.
- GRANT_I: drive ramaddr = iaddr[owner] and ramREN=1.
- Completion: the access completes in a cycle with ramstate==ACCESS. In that cycle the owner's wait is 0 and its load equals ramload. dload/iload are combinational passthroughs for the owner; non-owners' load outputs are 0.
- Completion is counted per access:
  - GRANT_D: word_cnt increments on each completed access. After the access with word_cnt==BLOCK_WORDS-1 → IDLE.
  - GRANT_I: release after 1 access.
- Early release: if the owner deasserts its request in GRANT_D or GRANT_I, go to IDLE on the next edge without further RAM activity.
- On every release, rr_ptr = owner+1 (mod NCPU).
- BUSY, FREE, or ERROR while granted: hold the grant, keep the owner's wait=1, and keep driving the request. An ERROR access is retried; it is not counted in word_cnt.
- Non-owners always see wait=1.

## Timing
- Arbitration latency: a request seen in IDLE drives the RAM starting the next cycle. Minimum latency from request to first wait=0 is 2 cycles, given ramstate==ACCESS immediately.
- Back-to-back grants: after release, at least one IDLE cycle occurs before the next grant.
- Reset (asynchronous, including mid-burst) returns:
  - state IDLE, owner=0, word_cnt=0, rr_ptr=0
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0
  - all iwait/dwait=1, all iload/dload=0
- RAM outputs are 0 in IDLE.
- Simultaneous release and new request from the same core: the core re-competes in IDLE with the lowest round-robin priority.

## Configuration
- MEM_ARBITER_PERF_EN defined:
  - Add output perf_grants (NCPU x 32): grants per core. The counter increments at grant, for both icache and dcache grants.
  - Add output perf_stall (NCPU x 32): cycles a core had any request high while not the owner.
  - Both counters are reset to 0 and wrap at 2^32.
- Macro undefined: the outputs and counters are absent and behaviour is otherwise identical.

## Structure
- cpu_types_pkg already supplies word_t and ramstate_t. Add arb_state_t (IDLE, GRANT_D, GRANT_I) to cpu_types_pkg.
- Natural sub-module: rr_picker. It is combinational: inputs are a request vector and rr_ptr, outputs are a one-hot grant and a valid flag. It is instantiated twice, once for the dcache request vector and once for the icache request vector.

## Test plan
- NCPU=2; core0 iREN, iaddr=0x40; ramstate ACCESS on every cycle → ramaddr=0x40 in cycle 1; iwait[0]=0 in cycle 1 with iload[0]=ramload; state IDLE in cycle 2.
- Core1 dREN for 2 words at 0x100/0x104 while core0 iREN is held → both dcache words are served before any icache access; dwait[1]=0 twice; iwait[0] stays 1 until after the release.
- Both cores issue dWEN with rr_ptr=0 → core0 writes 2 words, then core1; rr_ptr=1 and then 0 after each release; ramWEN=1 and ramREN=0 throughout.
- Core0 dREN granted and ramstate BUSY for 3 cycles, then ACCESS → dwait[0] stays 1 for 3 cycles; word_cnt is unchanged until the ACCESS cycle.
- ramstate ERROR once mid-block → the same address is reissued; word_cnt is not incremented; exactly 2 completions occur.
- n_rst asserted while word_cnt=1 in GRANT_D → ramREN/ramWEN go to 0 immediately; dwait=all 1; state IDLE after reset release.
